// File: rtl/dr_fa_driver.sv
// Drives a dual-rail full adder through a DATA/NULL four-phase cycle and returns single-rail results.
// Latency 2*(SYNC_STAGES+1) cycles from accept to out_valid; holds the result until out_ready.
// Optional DR_ILLEGAL_CHECK_EN: a synchronized 11 code on s or c_out forces ERR.
module dr_fa_driver #(
    parameter int TIMEOUT     = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_a,
    input  logic       in_b,
    input  logic       in_c,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_s,
    output logic       out_c,
    output logic       err,
    output logic [1:0] a,
    output logic [1:0] b,
    output logic [1:0] c_in,
    output logic       fn_en,
    input  logic [1:0] s,
    input  logic [1:0] c_out
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        DATA_WAIT,
        NULL_WAIT,
        OUT,
        ERR
    } state_t;

    state_t                          state;
    logic [SYNC_STAGES-1:0][3:0]     sync_q;
    logic [CW-1:0]                   wait_cnt;
    logic [1:0]                      s_sy;
    logic [1:0]                      c_sy;
    logic                            both_data;
    logic                            both_null;
    logic                            timed_out;
    logic                            illegal;
    logic                            fault;

    // The adder outputs are asynchronous to clk; only the last stage is ever looked at.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {c_out, s}};
        end
    end

    assign s_sy      = sync_q[SYNC_STAGES-1][1:0];
    assign c_sy      = sync_q[SYNC_STAGES-1][3:2];
    assign both_data = ((s_sy == 2'b01) || (s_sy == 2'b10)) &&
                       ((c_sy == 2'b01) || (c_sy == 2'b10));
    assign both_null = (s_sy == 2'b00) && (c_sy == 2'b00);
    assign timed_out = (wait_cnt == CW'(TIMEOUT));

`ifdef DR_ILLEGAL_CHECK_EN
    assign illegal = (s_sy == 2'b11) || (c_sy == 2'b11);
`else
    assign illegal = 1'b0;
`endif

    // Completion wins over a timeout that expires on the same cycle.
    assign fault = illegal ||
                   (timed_out && (((state == DATA_WAIT) && !both_data) ||
                                  ((state == NULL_WAIT) && !both_null)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_s     <= 1'b0;
            out_c     <= 1'b0;
            err       <= 1'b0;
            a         <= 2'b00;
            b         <= 2'b00;
            c_in      <= 2'b00;
            fn_en     <= 1'b0;
            wait_cnt  <= '0;
        end else if (fault) begin
            state     <= ERR;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b1;
            a         <= 2'b00;
            b         <= 2'b00;
            c_in      <= 2'b00;
            fn_en     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a        <= in_a ? 2'b10 : 2'b01;
                        b        <= in_b ? 2'b10 : 2'b01;
                        c_in     <= in_c ? 2'b10 : 2'b01;
                        fn_en    <= 1'b1;
                        in_ready <= 1'b0;
                        wait_cnt <= '0;
                        state    <= DATA_WAIT;
                    end
                end
                DATA_WAIT: begin
                    if (both_data) begin
                        out_s    <= s_sy[1];
                        out_c    <= c_sy[1];
                        a        <= 2'b00;
                        b        <= 2'b00;
                        c_in     <= 2'b00;
                        wait_cnt <= '0;
                        state    <= NULL_WAIT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                NULL_WAIT: begin
                    if (both_null) begin
                        fn_en     <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state    <= ERR;
                    err      <= 1'b1;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dr_fa_driver.sv
// Randomized scoreboard bench for dr_fa_driver with a behavioural dual-rail adder model.
module tb_dr_fa_driver;

    localparam int SS   = 2;
    localparam int TO   = 16;
    localparam int LAT  = 2 * (SS + 1);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_a = 1'b0, in_b = 1'b0, in_c = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_s, out_c, err;
    logic [1:0] a, b, c_in;
    logic       fn_en;
    logic [1:0] s, c_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int sent   = 0;
    int hs_cnt = 0;
    int or_mode = 1;     // 0: hold low, 1: hold high, 2: random
    int adder_mode = 0;  // 0: normal, 1: never DATA, 2: s drives 11

    typedef struct {
        bit s;
        bit c;
        int acc;
    } exp_t;
    exp_t sb[$];

    dr_fa_driver #(.TIMEOUT(TO), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_c(out_c), .err(err),
        .a(a), .b(b), .c_in(c_in), .fn_en(fn_en),
        .s(s), .c_out(c_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Zero-delay adder: DATA when enabled with all inputs DATA, NULL otherwise.
    always_comb begin
        int tot;
        s     = 2'b00;
        c_out = 2'b00;
        tot   = int'(a[1]) + int'(b[1]) + int'(c_in[1]);
        if (fn_en && a != 2'b00 && b != 2'b00 && c_in != 2'b00) begin
            if (adder_mode == 0) begin
                s     = (tot % 2 == 1) ? 2'b10 : 2'b01;
                c_out = (tot >= 2)     ? 2'b10 : 2'b01;
            end else if (adder_mode == 2) begin
                s     = 2'b11;
                c_out = 2'b01;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        case (or_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops on each new result and checks hold-stability under backpressure.
    bit prev_vld = 0, prev_hs = 0, prev_s = 0, prev_c = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_vld = 0;
            prev_hs  = 0;
        end else begin
            if (out_valid) chk("in_ready_busy", in_ready, 0);
            if (out_valid && !prev_vld) begin
                if (sb.size() == 0) begin
                    fail("unexpected_output");
                end else begin
                    e = sb.pop_front();
                    chk("out_s", out_s, e.s);
                    chk("out_c", out_c, e.c);
                    chk("latency", cyc - e.acc, LAT);
                    chk("rails_null", {a, b, c_in}, 6'b0);
                end
            end else if (out_valid && prev_vld && !prev_hs) begin
                chk("hold_stable", {out_s, out_c}, {prev_s, prev_c});
            end
            if (out_valid && out_ready) hs_cnt++;
            prev_vld = out_valid;
            prev_hs  = out_valid && out_ready;
            prev_s   = out_s;
            prev_c   = out_c;
        end
    end

    task automatic send(input bit x, input bit y, input bit z, input bit expect_out, output int acc);
        int n = 0;
        int tot;
        exp_t e;
        acc = -1;
        @(negedge clk);
        in_a = x; in_b = y; in_c = z; in_valid = 1'b1;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            fail("accept_wait");
            in_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        if (expect_out) begin
            tot   = int'(x) + int'(y) + int'(z);
            e.s   = bit'(tot % 2);
            e.c   = bit'(tot / 2);
            e.acc = acc;
            sb.push_back(e);
            sent++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || out_valid) fail("drain");
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int acc;
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rails", {a, b, c_in}, 6'b0);
        chk("rst_fn_en", fn_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sc", {out_s, out_c}, 2'b00);
        chk("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        // V1: 1+1+0
        or_mode = 1;
        send(1, 1, 0, 1, acc);
        chk("v1_rails_data", {a, b, c_in}, 6'b10_10_01);
        chk("v1_fn_en", fn_en, 1);
        drain();

        // V2: all 8 combinations back-to-back
        for (int i = 0; i < 8; i++) send(i[2], i[1], i[0], 1, acc);
        drain();

        // V4: backpressure for 10 cycles while in_valid is offered
        or_mode = 0;
        send(1, 0, 1, 1, acc);
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        if (!out_valid) fail("v4_out_valid_wait");
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_a = 1'b1; in_b = 1'b1; in_c = 1'b1;
            @(negedge clk);
            chk("v4_in_ready_low", in_ready, 0);
            chk("v4_out_valid_held", out_valid, 1);
        end
        in_valid = 1'b0;
        or_mode = 1;
        n = 0;
        while (!out_ready && n < 10) begin @(negedge clk); n++; end
        @(negedge clk);
        chk("v4_released", out_valid, 0);
        drain();

        // Random traffic with random backpressure
        or_mode = 2;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(1'($urandom), 1'($urandom), 1'($urandom), 1, acc);
        end
        drain();
        or_mode = 1;
        @(negedge clk);
        chk("result_count", hs_cnt, sent);

        // V5: reset during NULL_WAIT discards the transaction
        send(0, 1, 1, 1, acc);
        wait_cyc(acc + 4);
        chk("v5_null_wait_rails", {a, b, c_in}, 6'b0);
        sb.delete();
        sent--;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("v5_rails", {a, b, c_in}, 6'b0);
        chk("v5_out_valid", out_valid, 0);
        chk("v5_in_ready", in_ready, 1);
        repeat (LAT + 2) @(negedge clk);
        send(1, 1, 1, 1, acc);
        drain();

        // V3: adder never produces DATA
        adder_mode = 1;
        send(1, 0, 0, 0, acc);
        wait_cyc(acc + TO);
        chk("v3_err_before", err, 0);
        wait_cyc(acc + TO + 1);
        chk("v3_err", err, 1);
        chk("v3_rails", {a, b, c_in}, 6'b0);
        chk("v3_in_ready", in_ready, 0);
        chk("v3_fn_en", fn_en, 0);
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        chk("v3_stuck", {in_ready, err, out_valid}, 3'b010);
        in_valid = 1'b0;
        adder_mode = 0;
        do_reset();
        chk("v3_reset_err", err, 0);

        // V6: illegal 11 code on s
        adder_mode = 2;
        send(0, 0, 1, 0, acc);
`ifdef DR_ILLEGAL_CHECK_EN
        wait_cyc(acc + SS);
        chk("v6_err_before", err, 0);
        wait_cyc(acc + SS + 1);
        chk("v6_err", err, 1);
`else
        wait_cyc(acc + TO);
        chk("v6_err_before", err, 0);
        wait_cyc(acc + TO + 1);
        chk("v6_err", err, 1);
`endif
        adder_mode = 0;
        do_reset();
        send(0, 1, 0, 1, acc);
        drain();
        @(negedge clk);
        chk("final_count", hs_cnt, sent);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
